// File: rtl/seq_det_rr_sched.sv
// Round-robin scheduler sharing one Mealy non-overlapping "1101" detector
// across N serial requesters; reports per-grant match count on done.
module seq_det_rr_sched #(
  parameter int N         = 4,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         bit_in,
  input  logic [N-1:0]         bit_vld,
  output logic [N-1:0]         gnt,
  output logic                 det_hit,
  output logic [$clog2(N)-1:0] hit_id,
  output logic                 done,
  output logic [$clog2(N)-1:0] done_id,
  output logic [CNT_W-1:0]     done_count,
  output logic                 done_abort
);

  // state  | meaning
  // S_IDLE | waiting for any req, arbitrates from r_ptr
  // S_RUN  | granted lane streams bits into the detector
  // S_DONE | one-cycle report, pointer advances past cur_id
  localparam int ID_W = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {D0, D1, D2, D3} det_t;

  state_t            r_state, w_state_nxt;
  det_t              r_det, w_det_nxt;
  logic [ID_W-1:0]   r_ptr, r_cur_id;
  logic [CNT_W-1:0]  r_bit_cnt, r_hit_cnt;
  logic [N-1:0]      r_gnt;
  logic              r_det_hit, r_done, r_done_abort;
  logic [ID_W-1:0]   r_hit_id, r_done_id;
  logic [CNT_W-1:0]  r_done_count;

  logic [ID_W-1:0]   w_win, w_win_hi, w_win_lo, w_ptr_nxt;
  logic              w_any_hi, w_accept, w_match, w_abort, w_last, w_bit;
  logic [CNT_W-1:0]  w_bit_cnt_inc, w_hit_sat;

  // First set req at or above the pointer wins; otherwise wrap to the lowest set req.
  always_comb begin
    w_any_hi = 1'b0;
    w_win_hi = '0;
    w_win_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win_lo = ID_W'(i);
        if (ID_W'(i) >= r_ptr) begin
          w_win_hi = ID_W'(i);
          w_any_hi = 1'b1;
        end
      end
    end
    w_win = w_any_hi ? w_win_hi : w_win_lo;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_det_nxt     = r_det;
    w_accept      = 1'b0;
    w_match       = 1'b0;
    w_abort       = 1'b0;
    w_last        = 1'b0;
    w_bit         = bit_in[r_cur_id];
    w_bit_cnt_inc = r_bit_cnt + CNT_W'(1);
    w_hit_sat     = (r_hit_cnt == '1) ? r_hit_cnt : r_hit_cnt + CNT_W'(1);
    w_ptr_nxt     = (r_cur_id == ID_W'(N - 1)) ? '0 : r_cur_id + ID_W'(1);
    case (r_state)
      S_IDLE: if (|req) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!req[r_cur_id]) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DONE;
        end else if (bit_vld[r_cur_id]) begin
          w_accept = 1'b1;
          case (r_det)
            D0: w_det_nxt = w_bit ? D1 : D0;
            D1: w_det_nxt = w_bit ? D2 : D0;
            D2: w_det_nxt = w_bit ? D2 : D3;
            D3: begin
              w_det_nxt = D0;
              w_match   = w_bit;
            end
            default: w_det_nxt = D0;
          endcase
          if (w_bit_cnt_inc == CNT_W'(BURST_LEN)) begin
            w_last      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_det        <= D0;
      r_ptr        <= '0;
      r_cur_id     <= '0;
      r_bit_cnt    <= '0;
      r_hit_cnt    <= '0;
      r_gnt        <= '0;
      r_det_hit    <= 1'b0;
      r_hit_id     <= '0;
      r_done       <= 1'b0;
      r_done_id    <= '0;
      r_done_count <= '0;
      r_done_abort <= 1'b0;
    end else begin
      r_det_hit <= w_match;
      r_done    <= 1'b0;
      if (r_state == S_IDLE && |req) begin
        r_cur_id  <= w_win;
        r_gnt     <= N'(1) << w_win;
        r_bit_cnt <= '0;
        r_hit_cnt <= '0;
        r_det     <= D0;
      end
      if (w_accept) begin
        r_det     <= w_det_nxt;
        r_bit_cnt <= w_bit_cnt_inc;
        if (w_match) begin
          r_hit_cnt <= w_hit_sat;
          r_hit_id  <= r_cur_id;
        end
      end
      // A match on the final bit must already be reflected in the reported count.
      if (w_abort || w_last) begin
        r_gnt        <= '0;
        r_done       <= 1'b1;
        r_done_id    <= r_cur_id;
        r_done_count <= w_match ? w_hit_sat : r_hit_cnt;
        r_done_abort <= w_abort;
      end
      if (r_state == S_DONE) r_ptr <= w_ptr_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign det_hit    = r_det_hit;
  assign hit_id     = r_hit_id;
  assign done       = r_done;
  assign done_id    = r_done_id;
  assign done_count = r_done_count;
  assign done_abort = r_done_abort;

endmodule
